// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; ALU_ARBITER_RR_EN selects round-robin arbitration.
// Response arrives 2 cycles after accept (1+MULT_CYCLES for MULT); new requests wait until the response is taken.
module alu_arbiter #(
    parameter int unsigned MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    input  logic        req_skip0,
    input  logic        req_skip1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_skip,
    input  logic [31:0] alu_y,
    input  logic        alu_bga,
    input  logic        alu_bea,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_bga,
    output logic        rsp_bea,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] OP_MULT = 4'b0111;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic        r_skip;
    logic        r_id;
    logic [31:0] r_rsp_y;
    logic        r_rsp_bga;
    logic        r_rsp_bea;

    logic        w_accept;
    logic        w_win;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [3:0]  w_sel_op;
    logic        w_sel_skip;
    logic        w_rsp_take;

`ifdef ALU_ARBITER_RR_EN
    // r_prio names the requester that wins the next contention.
    logic r_prio;

    assign w_win = (&req_valid) ? r_prio : req_valid[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_win;
        end
    end
`else
    assign w_win = ~req_valid[0];
`endif

    assign w_accept   = (r_state == S_IDLE) && (|req_valid);
    assign w_sel_a    = w_win ? req_a1    : req_a0;
    assign w_sel_b    = w_win ? req_b1    : req_b0;
    assign w_sel_op   = w_win ? req_op1   : req_op0;
    assign w_sel_skip = w_win ? req_skip1 : req_skip0;
    assign w_rsp_take = rsp_ready[r_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_op      <= 4'd0;
            r_skip    <= 1'b0;
            r_id      <= 1'b0;
            r_rsp_y   <= 32'd0;
            r_rsp_bga <= 1'b0;
            r_rsp_bea <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_skip  <= w_sel_skip;
                        r_id    <= w_win;
                        r_cnt   <= (w_sel_op == OP_MULT && !w_sel_skip) ? 4'(MULT_CYCLES - 1) : 4'd0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_y   <= alu_y;
                        r_rsp_bga <= alu_bga;
                        r_rsp_bea <= alu_bea;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    // ALU sees only latched operands, and only while executing.
    assign alu_a      = (r_state == S_EXEC) ? r_a    : 32'd0;
    assign alu_b      = (r_state == S_EXEC) ? r_b    : 32'd0;
    assign alu_opcode = (r_state == S_EXEC) ? r_op   : 4'd0;
    assign alu_skip   = (r_state == S_EXEC) ? r_skip : 1'b0;
    assign rsp_valid  = (r_state == S_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_y      = r_rsp_y;
    assign rsp_bga    = r_rsp_bga;
    assign rsp_bea    = r_rsp_bea;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (y=b on skip; bga = b>a, bea = b==a).
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_op0, req_op1;
    logic        req_skip0, req_skip1;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_skip;
    logic [31:0] alu_y;
    logic        alu_bga, alu_bea;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_bga, rsp_bea;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MULT_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_skip0(req_skip0), .req_skip1(req_skip1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_skip(alu_skip),
        .alu_y(alu_y), .alu_bga(alu_bga), .alu_bea(alu_bea),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_bga(rsp_bga), .rsp_bea(rsp_bea),
        .busy(busy)
    );

    always_comb begin
        alu_y = 32'd0;
        if (alu_skip) begin
            alu_y = alu_b;
        end else begin
            case (alu_opcode)
                4'b0011: alu_y = alu_a + alu_b;
                4'b0100: alu_y = alu_a - alu_b;
                4'b0111: alu_y = alu_a * alu_b;
                default: alu_y = 32'd0;
            endcase
        end
        alu_bga = (alu_b > alu_a);
        alu_bea = (alu_b == alu_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_alu_zero(input string tag);
        check({tag, " alu_a"}, alu_a, 32'd0);
        check({tag, " alu_b"}, alu_b, 32'd0);
        check({tag, " alu_opcode"}, {28'd0, alu_opcode}, 32'd0);
        check({tag, " alu_skip"}, {31'd0, alu_skip}, 32'd0);
    endtask

    logic [1:0] exp_grant [4];

    initial begin
`ifdef ALU_ARBITER_RR_EN
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        req_op0 = 0; req_op1 = 0; req_skip0 = 0; req_skip1 = 0;
        tick();
        tick();
        check("rst req_ready", {30'd0, req_ready}, 32'd0);
        check("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst rsp_y", rsp_y, 32'd0);
        check("rst flags", {30'd0, rsp_bga, rsp_bea}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check_alu_zero("rst");
        reset = 1'b0;
        tick();
        #1;
        check("idle no req_ready", {30'd0, req_ready}, 32'd0);

        // Single ADD on requester 0
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 4'b0011; req_valid = 2'b01;
        #1;
        check("add accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00; req_a0 = 32'd99; req_b0 = 32'd1;
        #1;
        check("add exec busy", {31'd0, busy}, 32'd1);
        check("add exec req_ready", {30'd0, req_ready}, 32'd0);
        check("add exec rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("add exec alu_a", alu_a, 32'd5);
        check("add exec alu_op", {28'd0, alu_opcode}, 32'd3);
        tick();
        check("add rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("add rsp_y", rsp_y, 32'd12);
        check("add flags", {30'd0, rsp_bga, rsp_bea}, 32'b10);
        check_alu_zero("add resp");
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("add done rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("add done busy", {31'd0, busy}, 32'd0);

        // MULT on requester 1, three EXEC cycles
        req_a1 = 32'd6; req_b1 = 32'd7; req_op1 = 4'b0111; req_valid = 2'b10;
        #1;
        check("mult accept", {30'd0, req_ready}, 32'd2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            req_valid = 2'b00;
            check($sformatf("mult T+%0d rsp_valid", i), {30'd0, rsp_valid}, 32'd0);
            check($sformatf("mult T+%0d busy", i), {31'd0, busy}, 32'd1);
        end
        tick();
        check("mult rsp_valid", {30'd0, rsp_valid}, 32'd2);
        check("mult rsp_y", rsp_y, 32'd42);
        rsp_ready = 2'b01;
        tick();
        check("mult non-owner ready ignored", {30'd0, rsp_valid}, 32'd2);
        check("mult busy held", {31'd0, busy}, 32'd1);
        rsp_ready = 2'b10;
        tick();
        check("mult done rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("mult done busy", {31'd0, busy}, 32'd0);

        // Contention: both valid continuously, responses always taken
        req_a0 = 32'd1;  req_b0 = 32'd2;  req_op0 = 4'b0011;
        req_a1 = 32'd10; req_b1 = 32'd20; req_op1 = 4'b0011;
        rsp_ready = 2'b11; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("contend grant %0d", k), {30'd0, req_ready}, {30'd0, exp_grant[k]});
            tick();
            tick();
            check($sformatf("contend rsp_valid %0d", k), {30'd0, rsp_valid}, {30'd0, exp_grant[k]});
            check($sformatf("contend rsp_y %0d", k), rsp_y, exp_grant[k][0] ? 32'd3 : 32'd30);
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        tick();

        // Backpressure on requester 0 while requester 1 waits
        req_a0 = 32'd2; req_b0 = 32'd2; req_op0 = 4'b0011; req_valid = 2'b11;
        #1;
        check("bp accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp hold %0d rsp_valid", i), {30'd0, rsp_valid}, 32'd1);
            check($sformatf("bp hold %0d rsp_y", i), rsp_y, 32'd4);
            check($sformatf("bp hold %0d req_ready", i), {30'd0, req_ready}, 32'd0);
            tick();
        end
        check("bp flags", {30'd0, rsp_bga, rsp_bea}, 32'b01);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        check("bp pending grant", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check("bp req1 rsp_valid", {30'd0, rsp_valid}, 32'd2);
        check("bp req1 rsp_y", rsp_y, 32'd30);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b11;

        // Reset during EXEC of a SUB
        req_a0 = 32'd9; req_b0 = 32'd4; req_op0 = 4'b0100; req_valid = 2'b01;
        #1;
        check("sub accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("sub exec busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("mid rst rsp_y", rsp_y, 32'd0);
        check("mid rst flags", {30'd0, rsp_bga, rsp_bea}, 32'd0);
        check_alu_zero("mid rst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post rst %0d rsp_valid", i), {30'd0, rsp_valid}, 32'd0);
        end

        // Skip with MULT opcode takes the short path and passes b through
        req_a0 = 32'd1; req_b0 = 32'hDEADBEEF; req_op0 = 4'b0111; req_skip0 = 1'b1;
        rsp_ready = 2'b00; req_valid = 2'b01;
        #1;
        check("skip accept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("skip alu_skip", {31'd0, alu_skip}, 32'd1);
        check("skip T+1 rsp_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        check("skip rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("skip rsp_y", rsp_y, 32'hDEADBEEF);
        check("skip flags", {30'd0, rsp_bga, rsp_bea}, 32'b10);
        rsp_ready = 2'b01;
        tick();
        check("skip done busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
